// File: rtl/mul3_recon_if.sv
// mul3_recon_if: quotient/remainder input and reconstructed-dividend output handshakes
interface mul3_recon_if #(
  parameter int W_Q = 31
);
  logic           in_valid;
  logic           in_ready;
  logic [W_Q-1:0] in_q;
  logic [1:0]     in_r;
  logic           out_valid;
  logic           out_ready;
  logic [W_Q:0]   out_x;
  logic           out_ovf;
  logic           out_rerr;
  modport master (
    output in_valid, in_q, in_r, out_ready,
    input  in_ready, out_valid, out_x, out_ovf, out_rerr
  );
  modport slave (
    input  in_valid, in_q, in_r, out_ready,
    output in_ready, out_valid, out_x, out_ovf, out_rerr
  );
endinterface

// File: rtl/mul3_recon_pipe.sv
// mul3_recon_pipe: two-stage 3*Q+R reconstruction with split carry, error flags and saturating error counter
module mul3_recon_pipe #(
  parameter int W_Q   = 31,
  parameter int SPLIT = 16,
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mul3_recon_if.slave      bus,
  input  logic             err_clr,
  output logic [W_CNT-1:0] err_cnt
);
  localparam int W_HI = W_Q - SPLIT;
  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic [1:0]       s1_c_q, s1_c_d;
  logic [W_HI-1:0]  s1_qhi_q, s1_qhi_d;
  logic             s1_rerr_q, s1_rerr_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W_Q:0]     x_q, x_d;
  logic             ovf_q, ovf_d;
  logic             rerr_q, rerr_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [SPLIT+1:0] lo;
  logic [W_HI+1:0]  hi;
  logic             s2_adv, in_fire, out_fire, s2_load;
  assign s2_adv        = !s2_valid_q || bus.out_ready;
  assign bus.in_ready  = !s1_valid_q || s2_adv;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = s2_valid_q && bus.out_ready;
  assign s2_load       = s2_adv && s1_valid_q;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_x     = x_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_rerr  = rerr_q;
  assign err_cnt       = cnt_q;
  // Low half plus remainder in stage 1, high half plus carry in stage 2; {hi,lo} is the full 3*Q+R
  always_comb begin
    lo         = (SPLIT+2)'(bus.in_q[SPLIT-1:0]) * (SPLIT+2)'(3) + (SPLIT+2)'(bus.in_r);
    hi         = (W_HI+2)'(s1_qhi_q) * (W_HI+2)'(3) + (W_HI+2)'(s1_c_q);
    s1_valid_d = bus.in_ready ? bus.in_valid : s1_valid_q;
    s1_lo_d    = in_fire ? lo[SPLIT-1:0] : s1_lo_q;
    s1_c_d     = in_fire ? lo[SPLIT+1:SPLIT] : s1_c_q;
    s1_qhi_d   = in_fire ? bus.in_q[W_Q-1:SPLIT] : s1_qhi_q;
    s1_rerr_d  = in_fire ? (bus.in_r == 2'd3) : s1_rerr_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    x_d        = s2_load ? {hi[W_HI:0], s1_lo_q} : x_q;
    ovf_d      = s2_load ? hi[W_HI+1] : ovf_q;
    rerr_d     = s2_load ? s1_rerr_q : rerr_q;
    cnt_d      = err_clr ? '0
               : (out_fire && (ovf_q || rerr_q) && !(&cnt_q)) ? cnt_q + W_CNT'(1) : cnt_q;
  end
  // Pipeline and counter state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= '0;
      s1_qhi_q   <= '0;
      s1_rerr_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      ovf_q      <= 1'b0;
      rerr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c_q     <= s1_c_d;
      s1_qhi_q   <= s1_qhi_d;
      s1_rerr_q  <= s1_rerr_d;
      s2_valid_q <= s2_valid_d;
      x_q        <= x_d;
      ovf_q      <= ovf_d;
      rerr_q     <= rerr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mul3_recon_pipe.sv
// tb_mul3_recon_pipe: directed and randomized-handshake checks of the 3*Q+R reconstruction pipeline
module tb_mul3_recon_pipe;
  localparam int W_Q   = 31;
  localparam int W_CNT = 4;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             err_clr = 1'b0;
  logic [W_CNT-1:0] err_cnt;
  int               pass_cnt = 0;
  int               total = 0;
  logic [W_Q-1:0]   vq [5] = '{31'h55555555, 31'h55555555, 31'h7FFFFFFF, 31'd5, 31'h0000FFFF};
  logic [1:0]       vr [5] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2};
  logic [31:0]      vx [5] = '{32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFD, 32'd18, 32'h0002FFFF};
  logic             vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic             ve [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [W_CNT-1:0] vc [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};

  mul3_recon_if #(.W_Q(W_Q)) bus ();

  mul3_recon_pipe #(.W_Q(W_Q), .SPLIT(16), .W_CNT(W_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_q = '0; bus.in_r = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_x !== 32'h0) $display("FAIL rst_out_x got %h exp 0", bus.out_x); else pass_cnt++;
    total++; if (err_cnt !== 4'd0) $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_idle_valid got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_latency();
    bus.in_valid = 1'b1; bus.in_q = '0; bus.in_r = 2'd2;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL lat_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_cycle1_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL lat_cycle2_valid got %b exp 1", bus.out_valid); else pass_cnt++;
    total++; if ({bus.out_ovf, bus.out_rerr, bus.out_x} !== {2'b00, 32'd2})
      $display("FAIL lat_result got ovf=%b rerr=%b x=%h exp ovf=0 rerr=0 x=2", bus.out_ovf, bus.out_rerr, bus.out_x);
    else pass_cnt++;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_drained got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_values();
    int n;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_q = vq[i]; bus.in_r = vr[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 8) begin @(negedge clk); n++; end
      total++; if (bus.out_valid !== 1'b1) $display("FAIL val%0d_valid got %b exp 1", i, bus.out_valid); else pass_cnt++;
      total++; if (bus.out_x !== vx[i]) $display("FAIL val%0d_x got %h exp %h", i, bus.out_x, vx[i]); else pass_cnt++;
      total++; if (bus.out_ovf !== vo[i]) $display("FAIL val%0d_ovf got %b exp %b", i, bus.out_ovf, vo[i]); else pass_cnt++;
      total++; if (bus.out_rerr !== ve[i]) $display("FAIL val%0d_rerr got %b exp %b", i, bus.out_rerr, ve[i]); else pass_cnt++;
      @(negedge clk);
      total++; if (err_cnt !== vc[i]) $display("FAIL val%0d_err_cnt got %0d exp %0d", i, err_cnt, vc[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] sb [$];
    logic [33:0] held, exp_v, got_v;
    logic [63:0] v;
    logic        stalled = 1'b0;
    int          sent = 0;
    int          cyc = 0;
    while ((sent < 100 || sb.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      got_v = {bus.out_ovf, bus.out_rerr, bus.out_x};
      if (stalled) begin
        total++; if (!bus.out_valid || got_v !== held)
          $display("FAIL b2b_stall_hold got valid=%b %h exp valid=1 %h", bus.out_valid, got_v, held);
        else pass_cnt++;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.in_q      = 31'($urandom);
      bus.in_r      = 2'($urandom_range(0, 3));
      #1;
      total++; if (bus.in_ready !== !(sb.size() == 2 && !bus.out_ready))
        $display("FAIL b2b_in_ready got %b exp %b", bus.in_ready, !(sb.size() == 2 && !bus.out_ready));
      else pass_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL b2b_extra_result got %h exp none", got_v);
        else begin
          exp_v = sb.pop_front();
          if (got_v !== exp_v) $display("FAIL b2b_result got %h exp %h", got_v, exp_v); else pass_cnt++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        v = 64'(bus.in_q) * 64'd3 + 64'(bus.in_r);
        sb.push_back({v[63:32] != 0, bus.in_r == 2'd3, v[31:0]});
        sent++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = got_v;
    end
    total++; if (sent != 100 || sb.size() != 0)
      $display("FAIL b2b_complete got sent=%0d pending=%0d exp sent=100 pending=0", sent, sb.size());
    else pass_cnt++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (err_cnt !== 4'd0) $display("FAIL sat_clear got %0d exp 0", err_cnt); else pass_cnt++;
    bus.out_ready = 1'b1; bus.in_q = 31'd5; bus.in_r = 2'd3; bus.in_valid = 1'b1;
    repeat (17) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (err_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", err_cnt); else pass_cnt++;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_rerr !== 1'b1)
      $display("FAIL clr_err_result got valid=%b rerr=%b exp 1 1", bus.out_valid, bus.out_rerr);
    else pass_cnt++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (err_cnt !== 4'd0) $display("FAIL clr_priority got %0d exp 0", err_cnt); else pass_cnt++;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (err_cnt !== 4'd1) $display("FAIL clr_then_count got %0d exp 1", err_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    int n;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_q = 31'd7; bus.in_r = 2'd0;
    @(negedge clk);
    bus.in_q = 31'd8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
      $display("FAIL flush_full got in_ready=%b out_valid=%b exp 0 1", bus.in_ready, bus.out_valid);
    else pass_cnt++;
    total++; if (bus.out_x !== 32'd21) $display("FAIL flush_stall_x got %0d exp 21", bus.out_x); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_x !== 32'h0)
      $display("FAIL flush_async got valid=%b x=%h exp 0 0", bus.out_valid, bus.out_x);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_stale%0d got %b exp 0", i, bus.out_valid); else pass_cnt++;
    end
    bus.in_valid = 1'b1; bus.in_q = 31'd9; bus.in_r = 2'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 8) begin @(negedge clk); n++; end
    total++; if (bus.out_valid !== 1'b1 || bus.out_x !== 32'd28)
      $display("FAIL flush_post got valid=%b x=%0d exp 1 28", bus.out_valid, bus.out_x);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_back_to_back();
    test_saturation();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
